db4_analysis_dec: RTL and testbench

DB4_ANALYSIS_DEC -- requirements
Module: db4_analysis_dec

---
 rtl/db4_pkg.sv | 36 +++
 rtl/db4_poly_branch.sv | 44 ++++
 rtl/db4_analysis_dec.sv | 92 +++++++++
 tb/tb_db4_analysis_dec.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/db4_pkg.sv
// Shared constants and helpers for the DB4 two-band analysis decimator.
// Coefficients are Q.8 fixed point; the DB4_HIGHPASS_EN build option lives in db4_analysis_dec.
package db4_pkg;

   localparam int W_IN_DEF   = 8;
   localparam int W_OUT_DEF  = 9;
   localparam int COEF_W_DEF = 9;
   localparam int FRAC_DEF   = 8;

   // Lowpass g[k] and its quadrature mirror h[k] = (-1)^k g[3-k]
   localparam int G0 = 124;
   localparam int G1 = 214;
   localparam int G2 = 57;
   localparam int G3 = -33;
   localparam int H0 = -33;
   localparam int H1 = -57;
   localparam int H2 = 214;
   localparam int H3 = -124;

   localparam int SR_W = 48;

   // Round half up by 2^-frac, then clamp into a signed w_out-bit range
   function automatic logic signed [SR_W-1:0] sat_round(input logic signed [SR_W-1:0] acc,
                                                       input int frac,
                                                       input int w_out);
      logic signed [SR_W-1:0] one, r, hi, lo;
      one = 48'sd1;
      r   = (acc + (one <<< (frac - 1))) >>> frac;
      hi  = (one <<< (w_out - 1)) - one;
      lo  = -(one <<< (w_out - 1));
      if (r > hi) return hi;
      if (r < lo) return lo;
      return r;
   endfunction

endpackage

// File: rtl/db4_poly_branch.sv
// One two-tap polyphase branch: C_CUR*x + C_DLY*x_prev, where x_prev is the
// previous sample of this phase. Constant products are built from shifts and adds.
module db4_poly_branch
   import db4_pkg::*;
#(
   parameter int W_IN   = W_IN_DEF,
   parameter int COEF_W = COEF_W_DEF,
   parameter int SUM_W  = W_IN + COEF_W + 2,
   parameter int C_CUR  = 0,
   parameter int C_DLY  = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    en,
   input  logic signed [W_IN-1:0]  x,
   output logic signed [SUM_W-1:0] sum
);

   localparam int PW = W_IN + COEF_W;

   // Coefficient is elaboration-constant, so only the set bits become adders
   function automatic logic signed [PW-1:0] cmul(input logic signed [W_IN-1:0] xv, input int c);
      logic signed [PW-1:0] xe, acc;
      int m;
      xe  = PW'(xv);
      acc = '0;
      m   = (c < 0) ? -c : c;
      for (int i = 0; i < COEF_W; i++)
         if (m[i]) acc = acc + (xe <<< i);
      return (c < 0) ? -acc : acc;
   endfunction

   logic signed [W_IN-1:0] x_d_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   x_d_p0 <= '0;
      else if (clear) x_d_p0 <= '0;
      else if (en)    x_d_p0 <= x;
   end

   assign sum = SUM_W'(cmul(x, C_CUR)) + SUM_W'(cmul(x_d_p0, C_DLY));

endmodule

// File: rtl/db4_analysis_dec.sv
// DB4 analysis filter with 2:1 decimation, built from even/odd polyphase branches.
// Define DB4_HIGHPASS_EN to add the detail band (highpass branches and the y_hi port).
module db4_analysis_dec
   import db4_pkg::*;
#(
   parameter int W_IN   = W_IN_DEF,
   parameter int W_OUT  = W_OUT_DEF,
   parameter int COEF_W = COEF_W_DEF,
   parameter int FRAC   = FRAC_DEF
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic signed [W_IN-1:0]  x_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [W_OUT-1:0] y_lo,
`ifdef DB4_HIGHPASS_EN
   output logic signed [W_OUT-1:0] y_hi,
`endif
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int SUM_W = W_IN + COEF_W + 2;

   logic phase_p0;   // 1 when the next accepted sample has an odd index
   logic take, take_even, take_odd;

   assign in_ready  = !(out_valid && !out_ready);
   assign take      = in_valid && in_ready && !clear;
   assign take_even = take && !phase_p0;
   assign take_odd  = take && phase_p0;

   logic signed [SUM_W-1:0] lo_even_sum, lo_odd_sum, lo_odd_p0, lo_tot;

   db4_poly_branch #(.W_IN(W_IN), .COEF_W(COEF_W), .SUM_W(SUM_W), .C_CUR(G0), .C_DLY(G2)) u_lo_even (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(take_even), .x(x_in), .sum(lo_even_sum));

   db4_poly_branch #(.W_IN(W_IN), .COEF_W(COEF_W), .SUM_W(SUM_W), .C_CUR(G1), .C_DLY(G3)) u_lo_odd (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(take_odd), .x(x_in), .sum(lo_odd_sum));

   assign lo_tot = lo_even_sum + lo_odd_p0;

   // Odd partial sum is parked until the even sample of the pair arrives
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_p0  <= 1'b0;
         out_valid <= 1'b0;
         lo_odd_p0 <= '0;
         y_lo      <= '0;
      end else if (clear) begin
         phase_p0  <= 1'b0;
         out_valid <= 1'b0;
         lo_odd_p0 <= '0;
      end else begin
         if (take)     phase_p0  <= !phase_p0;
         if (take_odd) lo_odd_p0 <= lo_odd_sum;
         if (take_even) begin
            y_lo      <= W_OUT'(sat_round(SR_W'(lo_tot), FRAC, W_OUT));
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef DB4_HIGHPASS_EN
   logic signed [SUM_W-1:0] hi_even_sum, hi_odd_sum, hi_odd_p0, hi_tot;

   db4_poly_branch #(.W_IN(W_IN), .COEF_W(COEF_W), .SUM_W(SUM_W), .C_CUR(H0), .C_DLY(H2)) u_hi_even (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(take_even), .x(x_in), .sum(hi_even_sum));

   db4_poly_branch #(.W_IN(W_IN), .COEF_W(COEF_W), .SUM_W(SUM_W), .C_CUR(H1), .C_DLY(H3)) u_hi_odd (
      .clk(clk), .reset_n(reset_n), .clear(clear), .en(take_odd), .x(x_in), .sum(hi_odd_sum));

   assign hi_tot = hi_even_sum + hi_odd_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_odd_p0 <= '0;
         y_hi      <= '0;
      end else if (clear) begin
         hi_odd_p0 <= '0;
      end else begin
         if (take_odd)  hi_odd_p0 <= hi_odd_sum;
         if (take_even) y_hi      <= W_OUT'(sat_round(SR_W'(hi_tot), FRAC, W_OUT));
      end
   end
`endif

endmodule

// File: tb/tb_db4_analysis_dec.sv
// Scoreboard bench for db4_analysis_dec: a default-width and an 8-bit-output instance
// share stimulus; a sample-list reference model predicts each decimated output.
module tb_db4_analysis_dec;

   localparam int FRAC = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic signed [7:0] x_in = '0;
   logic in_ready, in_ready8, out_valid, out_valid8;
   logic signed [8:0] y_lo;
   logic signed [7:0] y_lo8;
`ifdef DB4_HIGHPASS_EN
   logic signed [8:0] y_hi;
   logic signed [7:0] y_hi8;
`endif

   always #5 clk = ~clk;

   db4_analysis_dec dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_in(x_in), .in_valid(in_valid),
      .in_ready(in_ready), .y_lo(y_lo),
`ifdef DB4_HIGHPASS_EN
      .y_hi(y_hi),
`endif
      .out_valid(out_valid), .out_ready(out_ready));

   db4_analysis_dec #(.W_OUT(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_in(x_in), .in_valid(in_valid),
      .in_ready(in_ready8), .y_lo(y_lo8),
`ifdef DB4_HIGHPASS_EN
      .y_hi(y_hi8),
`endif
      .out_valid(out_valid8), .out_ready(out_ready));

   typedef struct { int lo; int hi; } exp_t;
   exp_t q[$];
   int   xs[$];
   int   g[4];
   int   h[4];
   int   checks = 0;
   int   errors = 0;

   function automatic int rnd(input int s);
      return (s + (1 << (FRAC - 1))) >>> FRAC;
   endfunction

   function automatic int clampw(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: y[n] = sum_k c[k]*x[2n-k] over the accepted-sample history
   task automatic model_accept(input int x);
      int idx, slo, shi, j;
      exp_t e;
      xs.push_back(x);
      idx = xs.size() - 1;
      if (idx % 2 == 0) begin
         slo = 0;
         shi = 0;
         for (int k = 0; k < 4; k++) begin
            j = idx - k;
            if (j >= 0) begin
               slo += g[k] * xs[j];
               shi += h[k] * xs[j];
            end
         end
         e.lo = rnd(slo);
         e.hi = rnd(shi);
         q.push_back(e);
      end
   endtask

   task automatic model_flush();
      xs.delete();
      q.delete();
   endtask

   task automatic step(input logic v, input int x, input logic rdy, input logic clr, output logic acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      x_in      = 8'(x);
      out_ready = rdy;
      clear     = clr;
      @(negedge clk);
      acc = 1'b0;
      if (reset_n) begin
         if (clear) model_flush();
         else if (in_valid && in_ready) begin
            acc = 1'b1;
            model_accept(int'(x_in));
         end
      end
   endtask

   task automatic run_rand(input int cycles, input int pv, input int pr);
      logic acc;
      int   px;
      px = $urandom_range(255) - 128;
      for (int i = 0; i < cycles; i++) begin
         step(($urandom_range(99) < pv), px, ($urandom_range(99) < pr), 1'b0, acc);
         if (acc) px = $urandom_range(255) - 128;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      model_flush();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Monitor: compare whatever the DUT presents against the head of the queue
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         check("out_valid", int'(out_valid), int'(q.size() != 0));
         check("out_valid8", int'(out_valid8), int'(q.size() != 0));
         check("in_ready", int'(in_ready), int'(!(q.size() != 0 && !out_ready)));
         if (!reset_n) begin
            check("rst_y_lo", int'(y_lo), 0);
            check("rst_y_lo8", int'(y_lo8), 0);
`ifdef DB4_HIGHPASS_EN
            check("rst_y_hi", int'(y_hi), 0);
`endif
         end
         if (out_valid && q.size() != 0) begin
            e = q[0];
            check("y_lo", int'(y_lo), clampw(e.lo, 9));
            check("y_lo_w8", int'(y_lo8), clampw(e.lo, 8));
`ifdef DB4_HIGHPASS_EN
            check("y_hi", int'(y_hi), clampw(e.hi, 9));
            check("y_hi_w8", int'(y_hi8), clampw(e.hi, 8));
`endif
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      logic acc;
      g = '{124, 214, 57, -33};
      for (int k = 0; k < 4; k++) h[k] = ((k % 2) ? -1 : 1) * g[3 - k];

      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // impulse then zeros
      step(1'b1, 100, 1'b1, 1'b0, acc);
      repeat (7) step(1'b1, 0, 1'b1, 1'b0, acc);

      // constant extremes (saturation on the 8-bit instance)
      repeat (16) step(1'b1, 127, 1'b1, 1'b0, acc);
      repeat (16) step(1'b1, -128, 1'b1, 1'b0, acc);

      // backpressure: consumer stalled, then released
      run_rand(7, 100, 0);
      run_rand(8, 100, 100);

      run_rand(300, 70, 70);

      // reset mid-pair, then a sample presented together with clear
      step(1'b1, 30, 1'b1, 1'b0, acc);
      step(1'b1, -40, 1'b1, 1'b0, acc);
      step(1'b1, 90, 1'b1, 1'b0, acc);
      do_reset();
      step(1'b1, 111, 1'b1, 1'b1, acc);
      run_rand(40, 80, 80);

      // clear while a result is held
      run_rand(20, 100, 0);
      step(1'b1, 5, 1'b0, 1'b1, acc);
      run_rand(40, 80, 80);

      repeat (8) step(1'b0, 0, 1'b1, 1'b0, acc);
      check("drain_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
